// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
//   Multi-cycle MIPS control unit. Each instruction walks FETCH -> DECODE ->
//   EXEC [-> MEM] [-> WB], with a TRAP state entered for interrupts, illegal
//   instructions and data-memory timeouts. The instruction word is held in an
//   internal IR. All control outputs are decoded from State and IR and are
//   forced to 0 while reset is held low.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   InstrIn           instruction memory read data (latched in FETCH)
//   IRQ, IRQMask      level interrupt requests and per-line enables
//   PCSupervisor      kernel mode, suppresses interrupts only
//   MemReady          data memory completes the access this cycle
//   State             FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
//   IRWr, PCWr, PCSrc IR / PC load controls
//   RegDst .. LUOp    datapath control fields
//   ALUFun, MemToReg  ALU function and write-back source select
//   IRQAck            one-hot acknowledge during an interrupt TRAP
//   Cause             last trap cause: 0 none, 1 IRQ, 2 illegal, 3 bus timeout
module multi_cycle_controller #(
  parameter int IRQ_N       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      InstrIn,
  input  logic [IRQ_N-1:0] IRQ,
  input  logic [IRQ_N-1:0] IRQMask,
  input  logic             PCSupervisor,
  input  logic             MemReady,
  output logic [2:0]       State,
  output logic             IRWr,
  output logic             PCWr,
  output logic [2:0]       PCSrc,
  output logic [1:0]       RegDst,
  output logic             RegWr,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic             Sign,
  output logic             MemWr,
  output logic             MemRd,
  output logic             EXTOp,
  output logic             LUOp,
  output logic [5:0]       ALUFun,
  output logic [1:0]       MemToReg,
  output logic [IRQ_N-1:0] IRQAck,
  output logic [1:0]       Cause
);
  localparam int IW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_JALR
  } kind_t;

  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [1:0]    cause_q, cause_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [5:0] op, fn;
  logic [4:0] rt;
  assign op = ir_q[31:26];
  assign fn = ir_q[5:0];
  assign rt = ir_q[20:16];

  // rs/rd/shamt/immediate fields belong to the datapath, not to control
  logic unused_ir;
  assign unused_ir = ^{ir_q[25:21], ir_q[15:6]};

  // Instruction decode: class plus the ALU-side control fields
  kind_t      kind;
  logic       legal;
  logic [5:0] dec_alu;
  logic       dec_s1, dec_s2, dec_sg, dec_ext, dec_lu;

  always_comb begin
    kind    = K_R;
    legal   = 1'b1;
    dec_alu = 6'b000000;
    dec_s1  = 1'b0;
    dec_s2  = 1'b0;
    dec_sg  = 1'b0;
    dec_ext = 1'b0;
    dec_lu  = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: dec_sg = 1'b1;
          6'h22: begin dec_alu = 6'b000001; dec_sg = 1'b1; end
          6'h24: dec_alu = 6'b011000;
          6'h25: dec_alu = 6'b011110;
          6'h26: dec_alu = 6'b010110;
          6'h27: dec_alu = 6'b010001;
          6'h00: begin dec_alu = 6'b100000; dec_s1 = 1'b1; end
          6'h02: begin dec_alu = 6'b100001; dec_s1 = 1'b1; end
          6'h03: begin dec_alu = 6'b100011; dec_s1 = 1'b1; dec_sg = 1'b1; end
          6'h2a: begin dec_alu = 6'b110101; dec_sg = 1'b1; end
          6'h08: kind = K_JR;
          6'h09: kind = K_JALR;
          default: legal = 1'b0;
        endcase
      end
      6'h08: begin kind = K_I; dec_s2 = 1'b1; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h09: begin kind = K_I; dec_s2 = 1'b1; end
      6'h0c: begin kind = K_I; dec_s2 = 1'b1; dec_alu = 6'b011000; end
      6'h0d: begin kind = K_I; dec_s2 = 1'b1; dec_alu = 6'b011110; end
      6'h0a: begin kind = K_I; dec_s2 = 1'b1; dec_alu = 6'b110101; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h0b: begin kind = K_I; dec_s2 = 1'b1; dec_alu = 6'b110101; end
      6'h0f: begin kind = K_I; dec_s2 = 1'b1; dec_lu = 1'b1; end
      6'h23: begin kind = K_LW; dec_s2 = 1'b1; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h2b: begin kind = K_SW; dec_s2 = 1'b1; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h04: begin kind = K_BR; dec_alu = 6'b110011; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h05: begin kind = K_BR; dec_alu = 6'b110001; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h06: begin kind = K_BR; dec_alu = 6'b111101; dec_sg = 1'b1; dec_ext = 1'b1; end
      6'h07: begin kind = K_BR; dec_alu = 6'b111111; dec_sg = 1'b1; dec_ext = 1'b1; end
      // opcode 1 is only bltz when rt = 0 (bgez and friends are not supported)
      6'h01: begin kind = K_BR; dec_alu = 6'b111011; dec_sg = 1'b1; dec_ext = 1'b1; legal = (rt == 5'd0); end
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      default: legal = 1'b0;
    endcase
  end

  // Interrupt qualification; the loop runs high-to-low so the lowest set
  // line is the last assignment and wins.
  logic [IRQ_N-1:0] irq_live;
  logic             pend;
  logic [IW-1:0]    pend_idx;
  assign irq_live = IRQ & IRQMask;
  assign pend     = (|irq_live) & ~PCSupervisor;

  always_comb begin
    pend_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq_live[i]) pend_idx = IW'(i);
    end
  end

  // cnt_q counts completed MEM waits; this MEM cycle is number cnt_q+1
  logic mem_expired;
  assign mem_expired = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    cause_d  = cause_q;
    idx_d    = idx_q;
    cnt_d    = '0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCSrc    = 3'b000;
    RegDst   = 2'b00;
    RegWr    = 1'b0;
    ALUSrc1  = 1'b0;
    ALUSrc2  = 1'b0;
    Sign     = 1'b0;
    MemWr    = 1'b0;
    MemRd    = 1'b0;
    EXTOp    = 1'b0;
    LUOp     = 1'b0;
    ALUFun   = 6'b000000;
    MemToReg = 2'b00;
    IRQAck   = '0;
    if (reset) begin
      case (state_q)
        S_FETCH: begin
          IRWr    = 1'b1;
          ir_d    = InstrIn;
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (pend) begin
            state_d = S_TRAP;
            cause_d = 2'd1;
            idx_d   = pend_idx;
          end else if (!legal) begin
            state_d = S_TRAP;
            cause_d = 2'd2;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          ALUFun  = dec_alu;
          ALUSrc1 = dec_s1;
          ALUSrc2 = dec_s2;
          Sign    = dec_sg;
          EXTOp   = dec_ext;
          LUOp    = dec_lu;
          state_d = S_WB;
          case (kind)
            K_BR:  begin PCWr = 1'b1; PCSrc = 3'b001; state_d = S_FETCH; end
            K_J:   begin PCWr = 1'b1; PCSrc = 3'b010; state_d = S_FETCH; end
            K_JAL: begin
              PCWr = 1'b1; PCSrc = 3'b010; RegWr = 1'b1; RegDst = 2'b10; MemToReg = 2'b10;
              state_d = S_FETCH;
            end
            K_JR:  begin PCWr = 1'b1; PCSrc = 3'b011; state_d = S_FETCH; end
            K_JALR: begin
              PCWr = 1'b1; PCSrc = 3'b011; RegWr = 1'b1; RegDst = 2'b10; MemToReg = 2'b10;
              state_d = S_FETCH;
            end
            K_LW, K_SW: state_d = S_MEM;
            default: ;
          endcase
        end
        S_MEM: begin
          ALUFun  = dec_alu;
          ALUSrc2 = dec_s2;
          Sign    = dec_sg;
          EXTOp   = dec_ext;
          MemRd   = (kind == K_LW);
          MemWr   = (kind == K_SW);
          if (MemReady) begin
            if (kind == K_SW) begin
              PCWr    = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (mem_expired) begin
            state_d = S_TRAP;
            cause_d = 2'd3;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WB: begin
          RegWr    = 1'b1;
          PCWr     = 1'b1;
          RegDst   = (kind == K_R) ? 2'b00 : 2'b01;
          MemToReg = (kind == K_LW) ? 2'b01 : 2'b00;
          state_d  = S_FETCH;
        end
        S_TRAP: begin
          RegWr    = 1'b1;
          RegDst   = 2'b11;
          MemToReg = 2'b10;
          PCWr     = 1'b1;
          PCSrc    = (cause_q == 2'd1) ? 3'b100 : 3'b101;
          if (cause_q == 2'd1) IRQAck = IRQ_N'(1) << idx_q;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cause_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cause_q <= cause_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign State = reset ? state_q : 3'd0;
  assign Cause = reset ? cause_q : 2'd0;

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;
  localparam int IRQ_N = 4;
  localparam int TO    = 15;

  localparam int KR = 0, KI = 1, KLW = 2, KSW = 3, KBR = 4, KJ = 5, KJAL = 6, KJR = 7, KJALR = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      InstrIn;
  logic [IRQ_N-1:0] IRQ, IRQMask, IRQAck;
  logic             PCSupervisor, MemReady;
  logic [2:0]       State, PCSrc;
  logic             IRWr, PCWr, RegWr, ALUSrc1, ALUSrc2, Sign, MemWr, MemRd, EXTOp, LUOp;
  logic [1:0]       RegDst, MemToReg, Cause;
  logic [5:0]       ALUFun;

  always #5 clk = ~clk;

  multi_cycle_controller #(.IRQ_N(IRQ_N), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .InstrIn(InstrIn), .IRQ(IRQ), .IRQMask(IRQMask),
    .PCSupervisor(PCSupervisor), .MemReady(MemReady), .State(State), .IRWr(IRWr),
    .PCWr(PCWr), .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr), .ALUSrc1(ALUSrc1),
    .ALUSrc2(ALUSrc2), .Sign(Sign), .MemWr(MemWr), .MemRd(MemRd), .EXTOp(EXTOp),
    .LUOp(LUOp), .ALUFun(ALUFun), .MemToReg(MemToReg), .IRQAck(IRQAck), .Cause(Cause)
  );

  logic [31:0] obs;
  assign obs = {State, IRWr, PCWr, PCSrc, RegDst, RegWr, ALUSrc1, ALUSrc2, Sign,
                MemWr, MemRd, EXTOp, LUOp, ALUFun, MemToReg, IRQAck, Cause};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [5:0] alu;
    bit         s1, s2, sg, ext, lu;
  } ent_t;

  ent_t       tbl[$];
  int         ncmp = 0;
  int         nfail = 0;
  logic [1:0] cause_m;

  function automatic void put(input logic [5:0] op, input logic [5:0] fn, input int kind,
                              input logic [5:0] alu, input bit s1, input bit s2,
                              input bit sg, input bit ext, input bit lu);
    ent_t x;
    x.op = op; x.fn = fn; x.kind = kind; x.alu = alu;
    x.s1 = s1; x.s2 = s2; x.sg = sg; x.ext = ext; x.lu = lu;
    tbl.push_back(x);
  endfunction

  function automatic int lookup(input logic [31:0] w);
    int r = -1;
    foreach (tbl[i]) begin
      if (tbl[i].op == w[31:26] && (w[31:26] != 6'h00 || tbl[i].fn == w[5:0]) &&
          (w[31:26] != 6'h01 || w[20:16] == 5'd0))
        r = i;
    end
    return r;
  endfunction

  function automatic logic [31:0] pk(input logic [2:0] st, input logic irwr, input logic pcw,
      input logic [2:0] pcs, input logic [1:0] rd, input logic rw, input logic s1,
      input logic s2, input logic sg, input logic mw, input logic mr, input logic ext,
      input logic lu, input logic [5:0] alu, input logic [1:0] m2r, input logic [3:0] ack,
      input logic [1:0] cs);
    return {st, irwr, pcw, pcs, rd, rw, s1, s2, sg, mw, mr, ext, lu, alu, m2r, ack, cs};
  endfunction

  task automatic check(input string tag, input logic [31:0] ev);
    ncmp++;
    assert (obs === ev) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, ev);
    end
  endtask

  // Runs one instruction from FETCH to completion; called right after a negedge.
  // waits < 0: MemReady never rises. rst_at >= 0: reset is pulled low on that MEM cycle.
  task automatic run(input string nm, input logic [31:0] w, input logic [3:0] irq,
                     input logic [3:0] msk, input logic sup, input int waits, input int rst_at);
    int ph, k, e, idx;
    logic [1:0] tc, rd, m2r;
    logic [2:0] pcs;
    logic pcw, rw, rdy;
    logic [31:0] ev;
    ent_t t;
    ph = 0; k = 0; idx = 0; tc = 2'd0;
    e = lookup(w);
    t = '{default: 0};
    if (e >= 0) t = tbl[e];
    for (int cyc = 0; cyc < 40 && ph != 6; cyc++) begin
      InstrIn      = (ph == 0) ? w : $urandom;
      IRQ          = (ph == 1) ? irq : 4'($urandom);
      IRQMask      = (ph == 1) ? msk : 4'($urandom);
      PCSupervisor = (ph == 1) ? sup : 1'($urandom);
      rdy          = (waits >= 0 && k == waits);
      MemReady     = (ph == 3) ? rdy : 1'($urandom);
      if (ph == 3 && k == rst_at) reset = 1'b0;
      #1;
      ev = 32'h0;
      case (ph)
        0: begin
          ev = pk(3'd0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  6'd0, 2'd0, 4'd0, cause_m);
          ph = 1;
        end
        1: begin
          ev = pk(3'd1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  6'd0, 2'd0, 4'd0, cause_m);
          if ((|(irq & msk)) && !sup) begin
            for (int i = 3; i >= 0; i--) if (irq[i] & msk[i]) idx = i;
            tc = 2'd1; ph = 5;
          end else if (e < 0) begin
            tc = 2'd2; ph = 5;
          end else begin
            ph = 2;
          end
        end
        2: begin
          pcw = 1'b0; pcs = 3'd0; rw = 1'b0; rd = 2'd0; m2r = 2'd0; ph = 4;
          case (t.kind)
            KBR:   begin pcw = 1'b1; pcs = 3'd1; ph = 6; end
            KJ:    begin pcw = 1'b1; pcs = 3'd2; ph = 6; end
            KJAL:  begin pcw = 1'b1; pcs = 3'd2; rw = 1'b1; rd = 2'd2; m2r = 2'd2; ph = 6; end
            KJR:   begin pcw = 1'b1; pcs = 3'd3; ph = 6; end
            KJALR: begin pcw = 1'b1; pcs = 3'd3; rw = 1'b1; rd = 2'd2; m2r = 2'd2; ph = 6; end
            KLW, KSW: ph = 3;
            default: ;
          endcase
          ev = pk(3'd2, 1'b0, pcw, pcs, rd, rw, t.s1, t.s2, t.sg, 1'b0, 1'b0, t.ext, t.lu,
                  t.alu, m2r, 4'd0, cause_m);
        end
        3: begin
          if (!reset) begin
            ev = 32'h0; ph = 7;
          end else begin
            ev = pk(3'd3, 1'b0, (t.kind == KSW) && rdy, 3'd0, 2'd0, 1'b0, 1'b0, t.s2, t.sg,
                    t.kind == KSW, t.kind == KLW, t.ext, 1'b0, t.alu, 2'd0, 4'd0, cause_m);
            if (rdy) ph = (t.kind == KLW) ? 4 : 6;
            else if (k + 1 == TO) begin tc = 2'd3; ph = 5; end
            else k++;
          end
        end
        4: begin
          ev = pk(3'd4, 1'b0, 1'b1, 3'd0, (t.kind == KR) ? 2'd0 : 2'd1, 1'b1, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 6'd0, (t.kind == KLW) ? 2'd1 : 2'd0, 4'd0, cause_m);
          ph = 6;
        end
        5: begin
          cause_m = tc;
          ev = pk(3'd5, 1'b0, 1'b1, (tc == 2'd1) ? 3'd4 : 3'd5, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd2, (tc == 2'd1) ? 4'(1 << idx) : 4'd0, tc);
          ph = 6;
        end
        default: ;
      endcase
      check($sformatf("%s.c%0d", nm, cyc), ev);
      @(negedge clk);
      if (ph == 7) begin
        reset = 1'b1; cause_m = 2'd0; ph = 6;
      end
    end
    if (ph != 6) begin
      nfail++;
      $error("FAIL %s.timeout: observed unfinished expected completion", nm);
    end
  endtask

  localparam logic [31:0] ADD = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
  localparam logic [31:0] LW  = {6'h23, 5'd1, 5'd2, 16'd4};
  localparam logic [31:0] SW  = {6'h2b, 5'd1, 5'd2, 16'd8};
  localparam logic [31:0] JAL = {6'h03, 26'h10};
  localparam logic [31:0] ILL = {6'h3f, 26'h0};

  initial begin
    logic [31:0] w;
    int e, waits;
    put(6'h00, 6'h20, KR, 6'b000000, 0, 0, 1, 0, 0);
    put(6'h00, 6'h22, KR, 6'b000001, 0, 0, 1, 0, 0);
    put(6'h00, 6'h24, KR, 6'b011000, 0, 0, 0, 0, 0);
    put(6'h00, 6'h25, KR, 6'b011110, 0, 0, 0, 0, 0);
    put(6'h00, 6'h26, KR, 6'b010110, 0, 0, 0, 0, 0);
    put(6'h00, 6'h27, KR, 6'b010001, 0, 0, 0, 0, 0);
    put(6'h00, 6'h00, KR, 6'b100000, 1, 0, 0, 0, 0);
    put(6'h00, 6'h02, KR, 6'b100001, 1, 0, 0, 0, 0);
    put(6'h00, 6'h03, KR, 6'b100011, 1, 0, 1, 0, 0);
    put(6'h00, 6'h2a, KR, 6'b110101, 0, 0, 1, 0, 0);
    put(6'h00, 6'h08, KJR, 6'b000000, 0, 0, 0, 0, 0);
    put(6'h00, 6'h09, KJALR, 6'b000000, 0, 0, 0, 0, 0);
    put(6'h08, 6'h00, KI, 6'b000000, 0, 1, 1, 1, 0);
    put(6'h09, 6'h00, KI, 6'b000000, 0, 1, 0, 0, 0);
    put(6'h0c, 6'h00, KI, 6'b011000, 0, 1, 0, 0, 0);
    put(6'h0d, 6'h00, KI, 6'b011110, 0, 1, 0, 0, 0);
    put(6'h0a, 6'h00, KI, 6'b110101, 0, 1, 1, 1, 0);
    put(6'h0b, 6'h00, KI, 6'b110101, 0, 1, 0, 0, 0);
    put(6'h0f, 6'h00, KI, 6'b000000, 0, 1, 0, 0, 1);
    put(6'h23, 6'h00, KLW, 6'b000000, 0, 1, 1, 1, 0);
    put(6'h2b, 6'h00, KSW, 6'b000000, 0, 1, 1, 1, 0);
    put(6'h04, 6'h00, KBR, 6'b110011, 0, 0, 1, 1, 0);
    put(6'h05, 6'h00, KBR, 6'b110001, 0, 0, 1, 1, 0);
    put(6'h06, 6'h00, KBR, 6'b111101, 0, 0, 1, 1, 0);
    put(6'h07, 6'h00, KBR, 6'b111111, 0, 0, 1, 1, 0);
    put(6'h01, 6'h00, KBR, 6'b111011, 0, 0, 1, 1, 0);
    put(6'h02, 6'h00, KJ, 6'b000000, 0, 0, 0, 0, 0);
    put(6'h03, 6'h00, KJAL, 6'b000000, 0, 0, 0, 0, 0);

    // reset held low with busy inputs: every output must read 0
    reset = 1'b0; InstrIn = ADD; IRQ = 4'hf; IRQMask = 4'hf; PCSupervisor = 1'b0; MemReady = 1'b1;
    cause_m = 2'd0;
    @(negedge clk); #1; check("rst0", 32'h0);
    @(negedge clk); #1; check("rst1", 32'h0);
    @(negedge clk);
    reset = 1'b1;

    run("add",     ADD, 4'b0000, 4'b0000, 1'b0, 0, -1);
    run("lw_w3",   LW,  4'b0000, 4'b1111, 1'b0, 3, -1);
    run("sw_tmo",  SW,  4'b0000, 4'b1111, 1'b0, -1, -1);
    run("irq",     ADD, 4'b0110, 4'b1111, 1'b0, 0, -1);
    run("irq_sup", ADD, 4'b0110, 4'b1111, 1'b1, 0, -1);
    run("ill",     ILL, 4'b0000, 4'b1111, 1'b0, 0, -1);
    run("ill_irq", ILL, 4'b1000, 4'b1000, 1'b0, 0, -1);
    run("masked",  ADD, 4'b1111, 4'b0000, 1'b0, 0, -1);
    run("jal",     JAL, 4'b0000, 4'b0000, 1'b0, 0, -1);
    run("sw_w0",   SW,  4'b0000, 4'b0000, 1'b0, 0, -1);
    run("lw_rst",  LW,  4'b0000, 4'b0000, 1'b0, -1, 1);
    run("add2",    ADD, 4'b0000, 4'b0000, 1'b0, 0, -1);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        w = $urandom;
      end else begin
        e = int'($urandom_range(0, 27));
        w = $urandom;
        w[31:26] = tbl[e].op;
        if (tbl[e].op == 6'h00) w[5:0] = tbl[e].fn;
        if (tbl[e].op == 6'h01) w[20:16] = 5'd0;
      end
      waits = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      run($sformatf("rnd%0d", n), w,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
          4'($urandom), 1'($urandom), waits, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
